decode_pipe_ctrl: RTL and testbench

- Pipelined successor to the single-cycle control unit.
- Decodes the instruction held in the IF/ID register into a control bundle and registers it into the ID/EX stage together with the PC and instruction.
- Detects load-use hazards and inserts bubbles; honours branch/jump flushes and downstream back-pressure.
- Optionally decodes the RV32M extension and keeps saturating stall and flush performance counters.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/instr_decoder.sv | 132 +++++++++++++
 rtl/decode_pipe_ctrl.sv | 83 ++++++++
 tb/tb_decode_pipe_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the ID-stage decoder: ALU/immediate/result encodings,
// RV32 opcodes and the control bundle carried into EX.
package ctrl_pkg;

    localparam int ALUC_W = 5;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd9,
        ALU_SLTU   = 5'd10,
        ALU_PASSB  = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_U = 3'b100,
        IMM_J = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        result_src_e       result_src;
        logic              alu_src_a;
        logic              alu_src_b;
        imm_src_e          imm_src;
        logic [ALUC_W-1:0] alu_ctrl;
        logic              branch;
        logic              jump;
        logic [2:0]        funct3;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              illegal;
    } ctrl_t;

    // Base-ISA ALU op from funct3; alt selects SUB (000) or SRA (101).
    function automatic logic [ALUC_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational RV32I(+M) decode of one instruction into a ctrl_t bundle
// plus the source-register usage flags needed by the hazard unit.
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      d;
    logic       u1;
    logic       u2;
    logic       bad;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        d   = '0;
        u1  = 1'b0;
        u2  = 1'b0;
        bad = 1'b0;
        case (opcode)
            OP_R: begin
                d.reg_write = 1'b1;
                u1 = 1'b1;
                u2 = 1'b1;
                if (f7 == F7_BASE)
                    d.alu_ctrl = alu_base(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    d.alu_ctrl = alu_base(f3, 1'b1);
                else if (f7 == F7_MUL && ENABLE_M)
                    d.alu_ctrl = 5'(ALU_MUL) + {2'b00, f3};
                else
                    bad = 1'b1;
            end
            OP_IALU: begin
                d.reg_write = 1'b1;
                d.alu_src_b = 1'b1;
                d.imm_src   = IMM_I;
                d.alu_ctrl  = alu_base(f3, f3 == 3'b101 && f7[5]);
                u1 = 1'b1;
                if (f3 == 3'b001 && f7 != F7_BASE)
                    bad = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
                    bad = 1'b1;
            end
            OP_LOAD: begin
                d.reg_write  = 1'b1;
                d.mem_read   = 1'b1;
                d.result_src = RES_MEM;
                d.alu_src_b  = 1'b1;
                d.imm_src    = IMM_I;
                u1 = 1'b1;
            end
            OP_STORE: begin
                d.mem_write = 1'b1;
                d.alu_src_b = 1'b1;
                d.imm_src   = IMM_S;
                u1 = 1'b1;
                u2 = 1'b1;
            end
            OP_LUI: begin
                d.reg_write = 1'b1;
                d.alu_src_b = 1'b1;
                d.imm_src   = IMM_U;
                d.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                d.reg_write = 1'b1;
                d.alu_src_a = 1'b1;
                d.alu_src_b = 1'b1;
                d.imm_src   = IMM_U;
            end
            OP_JAL: begin
                d.reg_write  = 1'b1;
                d.jump       = 1'b1;
                d.result_src = RES_PC4;
                d.alu_src_a  = 1'b1;
                d.alu_src_b  = 1'b1;
                d.imm_src    = IMM_J;
            end
            OP_JALR: begin
                d.reg_write  = 1'b1;
                d.jump       = 1'b1;
                d.result_src = RES_PC4;
                d.alu_src_b  = 1'b1;
                d.imm_src    = IMM_I;
                u1 = 1'b1;
            end
            OP_BRANCH: begin
                d.branch  = 1'b1;
                d.imm_src = IMM_B;
                // EQ/NE compare by subtraction, LT/GE and LTU/GEU by set-less-than.
                case (f3[2:1])
                    2'b10:   d.alu_ctrl = ALU_SLT;
                    2'b11:   d.alu_ctrl = ALU_SLTU;
                    default: d.alu_ctrl = ALU_SUB;
                endcase
                u1 = 1'b1;
                u2 = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        d.funct3 = f3;
        d.rd     = instr[11:7];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        if (d.rd == 5'd0)
            d.reg_write = 1'b0;

        ctrl     = d;
        rs1_used = u1;
        rs2_used = u2;
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            rs1_used     = 1'b0;
            rs2_used     = 1'b0;
        end
    end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// ID stage of the pipeline: decode, load-use hazard detection, ID/EX register
// with flush/back-pressure handling, and saturating stall/flush counters.
module decode_pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid_i,
    input  logic [31:0]              instr_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     flush_i,
    input  logic                     ex_ready_i,
    output logic                     stall_o,
    output logic                     ex_valid_o,
    output logic [$bits(ctrl_t)-1:0] ex_ctrl_o,
    output logic [XLEN-1:0]          ex_pc_o,
    output logic [31:0]              ex_instr_o,
    output logic                     illegal_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    ctrl_t dec;
    ctrl_t ex_ctrl;
    logic  rs1_used;
    logic  rs2_used;
    logic  hazard;

    instr_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
        .instr    (instr_i),
        .ctrl     (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign ex_ctrl_o = ex_ctrl;

    assign hazard = id_valid_i && ex_valid_o && ex_ctrl.mem_read && (ex_ctrl.rd != 5'd0) &&
                    ((rs1_used && ex_ctrl.rd == instr_i[19:15]) ||
                     (rs2_used && ex_ctrl.rd == instr_i[24:20]));

    // A flush kills the ID/EX contents regardless of EX readiness, so it never stalls.
    assign stall_o = !flush_i && (hazard || !ex_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o <= 1'b0;
            ex_ctrl    <= '0;
            ex_pc_o    <= '0;
            ex_instr_o <= '0;
            illegal_o  <= 1'b0;
        end else if (flush_i || (ex_ready_i && hazard)) begin
            ex_valid_o <= 1'b0;
            ex_ctrl    <= '0;
            ex_pc_o    <= '0;
            ex_instr_o <= '0;
            illegal_o  <= 1'b0;
        end else if (ex_ready_i) begin
            ex_valid_o <= id_valid_i;
            ex_ctrl    <= dec;
            ex_pc_o    <= pc_i;
            ex_instr_o <= instr_i;
            illegal_o  <= id_valid_i && dec.illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_i && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed bench: one RV32M instance with wide counters and one base-ISA
// instance with 2-bit counters, both driven by the same ID-stage stimulus.
module tb_decode_pipe_ctrl;
    import ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            id_valid = 1'b0;
    logic            flush    = 1'b0;
    logic            ex_ready = 1'b1;
    logic [31:0]     instr    = '0;
    logic [XLEN-1:0] pc       = '0;

    logic                     stall, ex_valid, illegal;
    logic [$bits(ctrl_t)-1:0] ctrl_w;
    logic [XLEN-1:0]          ex_pc;
    logic [31:0]              ex_instr;
    logic [15:0]              scnt, fcnt;

    logic                     stall0, ex_valid0, illegal0;
    logic [$bits(ctrl_t)-1:0] ctrl_w0;
    logic [XLEN-1:0]          ex_pc0;
    logic [31:0]              ex_instr0;
    logic [1:0]               scnt0, fcnt0;

    ctrl_t ec, ec0;
    assign ec  = ctrl_w;
    assign ec0 = ctrl_w0;

    int n_chk  = 0;
    int n_fail = 0;

    decode_pipe_ctrl #(.XLEN(XLEN), .ENABLE_M(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .instr_i(instr), .pc_i(pc),
        .flush_i(flush), .ex_ready_i(ex_ready), .stall_o(stall), .ex_valid_o(ex_valid),
        .ex_ctrl_o(ctrl_w), .ex_pc_o(ex_pc), .ex_instr_o(ex_instr), .illegal_o(illegal),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    decode_pipe_ctrl #(.XLEN(XLEN), .ENABLE_M(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .instr_i(instr), .pc_i(pc),
        .flush_i(flush), .ex_ready_i(ex_ready), .stall_o(stall0), .ex_valid_o(ex_valid0),
        .ex_ctrl_o(ctrl_w0), .ex_pc_o(ex_pc0), .ex_instr_o(ex_instr0), .illegal_o(illegal0),
        .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [XLEN-1:0] p);
        id_valid = v;
        instr    = i;
        pc       = p;
    endtask

    initial begin
        #12;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ctrl_w, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_instr", ex_instr, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_cnts", {scnt, fcnt}, 0);
        rst_n = 1'b1;

        // add x3,x1,x2
        drive(1, 32'h002081B3, 32'h100);
        #1 chk("add_stall", stall, 0);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_alu", ec.alu_ctrl, 0);
        chk("add_regw", ec.reg_write, 1);
        chk("add_rd", ec.rd, 3);
        chk("add_illegal", illegal, 0);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_instr", ex_instr, 32'h002081B3);

        // lw x5 then lui x7 whose imm bits alias rs1=5: no rs1 use, no stall
        drive(1, 32'h0000A283, 32'h104);
        #1 chk("lw_stall", stall, 0);
        tick();
        chk("lw_memrd", ec.mem_read, 1);
        chk("lw_res", ec.result_src, 1);
        drive(1, 32'h0002B3B7, 32'h108);
        #1 chk("lui_nohaz", stall, 0);
        tick();
        chk("lui_alu", ec.alu_ctrl, 11);

        // lw x5 ; add x6,x5,x2 -> one bubble
        drive(1, 32'h0000A283, 32'h10C);
        tick();
        drive(1, 32'h00228333, 32'h110);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_bubctrl", ctrl_w, 0);
        chk("lu_stall_after", stall, 0);
        chk("lu_scnt", scnt, 1);
        tick();
        chk("lu_issue", ex_valid, 1);
        chk("lu_rd", ec.rd, 6);
        chk("lu_pc", ex_pc, 32'h110);

        // mul x3,x1,x2
        drive(1, 32'h022081B3, 32'h120);
        tick();
        chk("mul_alu", ec.alu_ctrl, 12);
        chk("mul_ill", illegal, 0);
        chk("mul0_ill", illegal0, 1);
        chk("mul0_ctrl_ill", ec0.illegal, 1);
        chk("mul0_writes", {ec0.reg_write, ec0.mem_write}, 0);
        chk("mul0_valid", ex_valid0, 1);

        // addi x0,x0,1
        drive(1, 32'h00100013, 32'h124);
        tick();
        chk("addi_regw", ec.reg_write, 0);
        chk("addi_srcb", ec.alu_src_b, 1);
        chk("addi_imm", ec.imm_src, 0);

        // jal x1,8
        drive(1, 32'h008000EF, 32'h128);
        tick();
        chk("jal_jbr", {ec.jump, ec.branch}, 2'b10);
        chk("jal_res", ec.result_src, 2'b10);
        chk("jal_imm", ec.imm_src, 3'b101);
        chk("jal_regw", ec.reg_write, 1);

        // slli with funct7 != 0, legal srai, unknown opcode, invalid slot
        drive(1, 32'h40109093, 32'h12C);
        tick();
        chk("slli_bad", {illegal, ec.reg_write}, 2'b10);
        drive(1, 32'h4010D093, 32'h130);
        tick();
        chk("srai_ok", {illegal, ec.alu_ctrl}, 6'd7);
        drive(1, 32'hFFFFFFFF, 32'h134);
        tick();
        chk("unk_ill", illegal, 1);
        drive(0, 32'hFFFFFFFF, 32'h138);
        tick();
        chk("inv_ill", {ex_valid, illegal}, 0);

        // back-pressure 3 cycles with flush in the 2nd
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1, 32'h002081B3, 32'h200);
        tick();
        ex_ready = 1'b0;
        drive(1, 32'h00100013, 32'h204);
        #1 chk("bp_stall1", stall, 1);
        tick();
        chk("bp_hold", {ex_valid, ec.rd}, {1'b1, 5'd3});
        chk("bp_hold_pc", ex_pc, 32'h200);
        flush = 1'b1;
        #1 chk("bp_flush_stall", stall, 0);
        tick();
        chk("bp_flush_valid", ex_valid, 0);
        chk("bp_flush_ctrl", ctrl_w, 0);
        flush = 1'b0;
        #1 chk("bp_stall3", stall, 1);
        tick();
        chk("bp_scnt", scnt, 2);
        chk("bp_fcnt", fcnt, 1);
        chk("bp_scnt0", scnt0, 2);

        // hazard under back-pressure, saturation, then reset mid-stall
        ex_ready = 1'b1;
        drive(1, 32'h0000A283, 32'h300);
        #1 chk("sat_lw_stall", stall, 0);
        tick();
        ex_ready = 1'b0;
        drive(1, 32'h00228333, 32'h304);
        tick();
        tick();
        tick();
        chk("sat_hold_lw", {ex_valid, ec.mem_read, ec.rd}, {1'b1, 1'b1, 5'd5});
        chk("sat_scnt", scnt, 5);
        chk("sat_scnt0", scnt0, 3);
        chk("sat_fcnt0", fcnt0, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {ex_valid, ex_valid0}, 0);
        chk("mrst_ctrl", ctrl_w, 0);
        chk("mrst_pcinstr", {ex_pc, ex_instr}, 0);
        chk("mrst_ill", illegal, 0);
        chk("mrst_cnts", {scnt, fcnt, scnt0, fcnt0}, 0);
        #1 rst_n = 1'b1;
        ex_ready = 1'b1;
        #1 chk("post_rst_stall", stall, 0);
        tick();
        chk("post_rst_issue", {ex_valid, ec.rd}, {1'b1, 5'd6});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
